point_packer: RTL

Upstream stage of the sequential BRAM loader. Accepts the per-point quotient bytes as a serial valid/ready stream, packs each group of 11 bytes into parallel registers, and presents them with a wrapping point index. It fires a one-cycle load enable and holds all outputs stable until the loader's done rises, then accepts the next point. Framing errors and loader timeouts are flagged sticky, so a broken stream or a stalled loader cannot wedge the capture path.

---
 rtl/point_packer_if.sv | 25 ++
 rtl/point_packer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/point_packer_if.sv
// point_packer_if: byte stream from the quotient producer into point_packer.
//   in_valid  producer -> packer  byte valid
//   in_data   producer -> packer  quotient byte (8 bits)
//   in_last   producer -> packer  marks byte 10 of a point
//   in_ready  packer -> producer  byte accepted when in_valid & in_ready
interface point_packer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/point_packer.sv
// point_packer: collects 11 quotient bytes per point from a valid/ready
// stream, presents them in parallel with a wrapping slot index, pulses
// load_en for one cycle and holds everything stable until the loader's
// done rises. Misplaced in_last and a loader that never finishes are
// reported through sticky flags; neither can lock up the capture path.
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-high
//   s_in           byte stream (point_packer_if.slave)
//   data_out0..10  packed quotient bytes, byte k of a point on data_outk
//   point_count    slot index of the point being loaded (wraps at MAX_POINTS)
//   load_en        one-cycle load pulse to the loader
//   load_done      loader done level; only its rising edge completes a load
//   framing_err    sticky, in_last seen on the wrong byte
//   timeout_err    sticky, loader did not complete within DONE_TIMEOUT cycles
module point_packer #(
    parameter int MAX_POINTS   = 1000,
    parameter int DONE_TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                reset,
    point_packer_if.slave       s_in,
    output logic [7:0]          data_out0,
    output logic [7:0]          data_out1,
    output logic [7:0]          data_out2,
    output logic [7:0]          data_out3,
    output logic [7:0]          data_out4,
    output logic [7:0]          data_out5,
    output logic [7:0]          data_out6,
    output logic [7:0]          data_out7,
    output logic [7:0]          data_out8,
    output logic [7:0]          data_out9,
    output logic [7:0]          data_out10,
    output logic [9:0]          point_count,
    output logic                load_en,
    input  logic                load_done,
    output logic                framing_err,
    output logic                timeout_err
);

    localparam int NUM_BYTES = 11;
    localparam logic [3:0]  LAST_IDX     = 4'(NUM_BYTES - 1);
    localparam logic [9:0]  LAST_POINT   = 10'(MAX_POINTS - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                       state_q,     state_d;
    logic [3:0]                   idx_q,       idx_d;
    logic [NUM_BYTES-1:0][7:0]    data_q,      data_d;
    logic [9:0]                   point_q,     point_d;
    logic                         load_en_q,   load_en_d;
    logic                         in_ready_q,  in_ready_d;
    logic                         framing_q,   framing_d;
    logic                         timeout_q,   timeout_d;
    logic                         done_prev_q, done_prev_d;
    logic [15:0]                  wait_cnt_q,  wait_cnt_d;

    logic accept;
    logic done_rise;

    // in_ready_q mirrors "state is COLLECT" so a byte is only taken there.
    assign accept    = s_in.in_valid & in_ready_q;
    assign done_rise = load_done & ~done_prev_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        point_d     = point_q;
        framing_d   = framing_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
        // Tracked in every state so a level already high on entry to
        // WAIT_DONE is never mistaken for a fresh completion.
        done_prev_d = load_done;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (idx_q == 4'(k)) begin
                            data_d[k] = s_in.in_data;
                        end
                    end
                    if (s_in.in_last && (idx_q == LAST_IDX)) begin
                        state_d = ISSUE;
                        idx_d   = 4'd0;
                    end else if (s_in.in_last || (idx_q == LAST_IDX)) begin
                        // Misframed point: drop it and resync on the next byte.
                        idx_d     = 4'd0;
                        framing_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT_DONE;
                // Counts clock edges since ISSUE began; ISSUE's own edge is 1,
                // so the abort lands exactly DONE_TIMEOUT cycles after ISSUE.
                wait_cnt_d = 16'd1;
            end

            WAIT_DONE: begin
                if (done_rise) begin
                    state_d = COLLECT;
                    point_d = (point_q == LAST_POINT) ? 10'd0 : point_q + 10'd1;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    // Slot is reused: point_count is left alone on abort.
                    state_d   = COLLECT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = COLLECT;
                idx_d   = 4'd0;
            end
        endcase

        // Registered outputs follow the next state.
        in_ready_d = (state_d == COLLECT);
        load_en_d  = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= 4'd0;
            data_q      <= '0;
            point_q     <= 10'd0;
            load_en_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            framing_q   <= 1'b0;
            timeout_q   <= 1'b0;
            done_prev_q <= 1'b0;
            wait_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            point_q     <= point_d;
            load_en_q   <= load_en_d;
            in_ready_q  <= in_ready_d;
            framing_q   <= framing_d;
            timeout_q   <= timeout_d;
            done_prev_q <= done_prev_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign s_in.in_ready = in_ready_q;
    assign data_out0     = data_q[0];
    assign data_out1     = data_q[1];
    assign data_out2     = data_q[2];
    assign data_out3     = data_q[3];
    assign data_out4     = data_q[4];
    assign data_out5     = data_q[5];
    assign data_out6     = data_q[6];
    assign data_out7     = data_q[7];
    assign data_out8     = data_q[8];
    assign data_out9     = data_q[9];
    assign data_out10    = data_q[10];
    assign point_count   = point_q;
    assign load_en       = load_en_q;
    assign framing_err   = framing_q;
    assign timeout_err   = timeout_q;

endmodule
